inv_aes_arbiter: RTL and testbench

INV_AES_ARBITER -- requirements
Module: inv_aes_arbiter

---
 rtl/inv_aes_arbiter.sv | 157 +++++++++++++++
 tb/tb_inv_aes_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_aes_arbiter.sv
// -----------------------------------------------------------------------------
// inv_aes_arbiter
//   Two-requester front end for a single inverse-AES (decryption) core.
//   Exactly one request is outstanding at the core at any time. Requests are
//   granted round-robin on a tie, issued to the core as a one-cycle pulse, and
//   the result (or a timeout error) is returned to the owning requester.
//
// Ports
//   clk, reset          : clock, asynchronous active-high reset
//   reqN_valid/ready    : request handshake, N = 0,1
//   reqN_data/key       : ciphertext and final-round key, captured on accept
//   rspN_valid/ready    : response handshake to requester N
//   rspN_data/err       : plaintext (0 on error) and timeout flag
//   core_data_valid     : one-cycle start pulse to the core
//   core_data/core_key  : operands presented to the core
//   core_res_valid/dec  : result strobe and plaintext from the core
//   busy                : high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module inv_aes_arbiter #(
   parameter int TIMEOUT = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [127:0] req0_data,
   input  logic [127:0] req0_key,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [127:0] req1_data,
   input  logic [127:0] req1_key,
   output logic         rsp0_valid,
   input  logic         rsp0_ready,
   output logic [127:0] rsp0_data,
   output logic         rsp0_err,
   output logic         rsp1_valid,
   input  logic         rsp1_ready,
   output logic [127:0] rsp1_data,
   output logic         rsp1_err,
   output logic         core_data_valid,
   output logic [127:0] core_data,
   output logic [127:0] core_key,
   input  logic         core_res_valid,
   input  logic [127:0] core_res_dec,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

   state_t       state_q, state_d;
   logic         last_grant_q, last_grant_d;
   logic         owner_q, owner_d;
   logic [127:0] data_q, data_d;
   logic [127:0] key_q, key_d;
   logic [127:0] res_q, res_d;
   logic         err_q, err_d;
   logic [15:0]  timer_q, timer_d;
   logic         grant0, grant1;

   // last_grant_q = 1 means requester 1 was served last, so requester 0 wins a tie.
   assign grant0 = req0_valid && (!req1_valid || last_grant_q);
   assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         data_q       <= '0;
         key_q        <= '0;
         res_q        <= '0;
         err_q        <= 1'b0;
         timer_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         data_q       <= data_d;
         key_q        <= key_d;
         res_q        <= res_d;
         err_q        <= err_d;
         timer_q      <= timer_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      data_d       = data_q;
      key_d        = key_q;
      res_d        = res_q;
      err_d        = err_q;
      timer_d      = timer_q;
      req0_ready   = 1'b0;
      req1_ready   = 1'b0;

      case (state_q)
         IDLE: begin
            // Ready is gated by reset so every output reads 0 while reset is held.
            req0_ready = grant0 && !reset;
            req1_ready = grant1 && !reset;
            if (grant0) begin
               owner_d = 1'b0;
               data_d  = req0_data;
               key_d   = req0_key;
               state_d = ISSUE;
            end else if (grant1) begin
               owner_d = 1'b1;
               data_d  = req1_data;
               key_d   = req1_key;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = '0;
            state_d = WAIT;
         end
         WAIT: begin
            timer_d = timer_q + 16'd1;
            // A result arriving on the last allowed cycle still beats the timeout.
            if (core_res_valid) begin
               res_d   = core_res_dec;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (timer_q == TIMER_LAST) begin
               res_d   = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end
         end
         RESP: begin
            if (owner_q ? rsp1_ready : rsp0_ready) begin
               last_grant_d = owner_q;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign busy            = (state_q != IDLE);
   assign core_data_valid = (state_q == ISSUE);
   assign core_data       = data_q;
   assign core_key        = key_q;

   // Only the owner sees a response; the other requester's outputs stay 0.
   assign rsp0_valid = (state_q == RESP) && !owner_q;
   assign rsp1_valid = (state_q == RESP) && owner_q;
   assign rsp0_data  = rsp0_valid ? res_q : '0;
   assign rsp1_data  = rsp1_valid ? res_q : '0;
   assign rsp0_err   = rsp0_valid && err_q;
   assign rsp1_err   = rsp1_valid && err_q;

endmodule

// File: tb/tb_inv_aes_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inv_aes_arbiter
//   Directed bench for inv_aes_arbiter with TIMEOUT = 16. A small core model
//   returns (data ^ key) after a programmable latency, counted from the ISSUE
//   cycle: latency L puts core_res_valid in the L-th cycle after ISSUE, which
//   is WAIT cycle L (timer = L-1). The response state follows one cycle later.
//   Inputs are driven and outputs sampled around the falling edge.
// -----------------------------------------------------------------------------
module tb_inv_aes_arbiter;

   localparam int TO = 16;
   localparam logic [127:0] D0 = 128'h3925841D02DC09FBDC118597196A0B32;
   localparam logic [127:0] K0 = 128'h5468617473206D79204B756E67204675;
   localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
   localparam logic [127:0] K1 = 128'h0F0E0D0C0B0A09080706050403020100;
   localparam logic [127:0] D2 = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
   localparam logic [127:0] K2 = 128'h13579BDF2468ACE0FEDCBA9876543210;

   logic         clk;
   logic         reset;
   logic         req0_valid, req0_ready, req1_valid, req1_ready;
   logic [127:0] req0_data, req0_key, req1_data, req1_key;
   logic         rsp0_valid, rsp0_ready, rsp0_err, rsp1_valid, rsp1_ready, rsp1_err;
   logic [127:0] rsp0_data, rsp1_data;
   logic         core_data_valid, core_res_valid;
   logic [127:0] core_data, core_key, core_res_dec;
   logic         busy;

   int errors = 0;
   int checks = 0;

   logic         model_en  = 1'b1;
   int           model_lat = 11;
   int           model_cnt = 0;
   logic [127:0] model_res = '0;

   inv_aes_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_data(req0_data), .req0_key(req0_key),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_data(req1_data), .req1_key(req1_key),
      .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
      .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
      .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
      .core_data_valid(core_data_valid), .core_data(core_data), .core_key(core_key),
      .core_res_valid(core_res_valid), .core_res_dec(core_res_dec),
      .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Core model: capture on the start pulse, answer after model_lat cycles.
   initial begin
      core_res_valid = 1'b0;
      core_res_dec   = '0;
      forever begin
         @(negedge clk);
         if (core_data_valid && model_en) begin
            model_res = core_data ^ core_key;
            model_cnt = model_lat;
         end
         @(posedge clk);
         #1;
         core_res_valid = 1'b0;
         if (model_cnt > 0) begin
            model_cnt = model_cnt - 1;
            if (model_cnt == 0) begin
               core_res_valid = 1'b1;
               core_res_dec   = model_res;
            end
         end
      end
   end

   task automatic test_reset();
      @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready, busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_ready_busy: got %b expected 000", {req0_ready, req1_ready, busy});
      end
      checks++;
      if ({rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, core_data_valid} !== 5'b00000) begin
         errors++;
         $display("FAIL reset_flags: got %b expected 00000",
                  {rsp0_valid, rsp1_valid, rsp0_err, rsp1_err, core_data_valid});
      end
      checks++;
      if ((rsp0_data | rsp1_data | core_data | core_key) !== 128'h0) begin
         errors++;
         $display("FAIL reset_data: got %h expected 0", rsp0_data | rsp1_data | core_data | core_key);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_tie();
      int n;
      @(negedge clk);
      req0_data = D0; req0_key = K0; req1_data = D1; req1_key = K1;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL tie_first_grant: got %b expected 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      n = 0;
      while (rsp0_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rsp0_data !== (D0 ^ K0)) begin
         errors++;
         $display("FAIL tie_rsp0_data: got %h expected %h", rsp0_data, D0 ^ K0);
      end
      // First IDLE cycle after the response: waiting requester 1 is accepted at once.
      @(negedge clk);
      #1;
      checks++;
      if ({busy, req1_ready} !== 2'b01) begin
         errors++;
         $display("FAIL tie_second_grant: got %b expected 01", {busy, req1_ready});
      end
      @(negedge clk);
      req1_valid = 1'b0;
      #1;
      checks++;
      if (core_data_valid !== 1'b1 || core_data !== D1 || core_key !== K1) begin
         errors++;
         $display("FAIL tie_issue1: got %b %h expected 1 %h", core_data_valid, core_data, D1);
      end
      n = 0;
      while (rsp1_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rsp1_data !== (D1 ^ K1) || rsp0_valid !== 1'b0) begin
         errors++;
         $display("FAIL tie_rsp1: got %h v0=%b expected %h v0=0", rsp1_data, rsp0_valid, D1 ^ K1);
      end
      @(negedge clk);
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++;
         $display("FAIL tie_alternate: got %b expected 10", {req0_ready, req1_ready});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      n = 0;
      while (rsp0_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
   endtask

   task automatic test_single();
      int   n;
      logic leak;
      @(negedge clk);
      req0_data = D0; req0_key = K0;
      req0_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready, busy} !== 3'b100) begin
         errors++;
         $display("FAIL single_accept: got %b expected 100", {req0_ready, req1_ready, busy});
      end
      @(negedge clk);
      req0_valid = 1'b0;
      #1;
      checks++;
      if (core_data_valid !== 1'b1 || core_data !== D0 || core_key !== K0 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_issue: got v=%b d=%h k=%h expected 1 %h %h",
                  core_data_valid, core_data, core_key, D0, K0);
      end
      n = 0;
      leak = 1'b0;
      while (rsp0_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
         if (core_data_valid !== 1'b0 || rsp1_valid !== 1'b0) leak = 1'b1;
      end
      checks++;
      if (n !== 12) begin
         errors++;
         $display("FAIL single_latency: got %0d expected 12", n);
      end
      checks++;
      if (rsp0_data !== (D0 ^ K0) || rsp0_err !== 1'b0) begin
         errors++;
         $display("FAIL single_rsp: got %h err=%b expected %h err=0", rsp0_data, rsp0_err, D0 ^ K0);
      end
      checks++;
      if (leak !== 1'b0) begin
         errors++;
         $display("FAIL single_quiet: got %b expected 0", leak);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({busy, rsp0_valid} !== 2'b00) begin
         errors++;
         $display("FAIL single_idle: got %b expected 00", {busy, rsp0_valid});
      end
   endtask

   task automatic test_backpressure();
      int           n;
      logic         blocked;
      logic         stable;
      logic [127:0] d;
      logic         e;
      @(negedge clk);
      rsp0_ready = 1'b0;
      req0_data = D2; req0_key = K2;
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      req1_data = D1; req1_key = K1;
      req1_valid = 1'b1;
      #1;
      n = 0;
      blocked = 1'b1;
      while (rsp0_valid !== 1'b1 && n < 40) begin
         if (req1_ready !== 1'b0) blocked = 1'b0;
         @(negedge clk);
         #1;
         n++;
      end
      d = rsp0_data;
      e = rsp0_err;
      checks++;
      if (d !== (D2 ^ K2) || e !== 1'b0) begin
         errors++;
         $display("FAIL bp_rsp: got %h err=%b expected %h err=0", d, e, D2 ^ K2);
      end
      stable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         if (rsp0_valid !== 1'b1 || rsp0_data !== d || rsp0_err !== e) stable = 1'b0;
         if (req1_ready !== 1'b0) blocked = 1'b0;
      end
      checks++;
      if (stable !== 1'b1) begin
         errors++;
         $display("FAIL bp_stable: got %b expected 1", stable);
      end
      @(negedge clk);
      rsp0_ready = 1'b1;
      #1;
      if (req1_ready !== 1'b0) blocked = 1'b0;
      checks++;
      if (blocked !== 1'b1) begin
         errors++;
         $display("FAIL bp_req1_blocked: got %b expected 1", blocked);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({rsp0_valid, req1_ready} !== 2'b01) begin
         errors++;
         $display("FAIL bp_release: got %b expected 01", {rsp0_valid, req1_ready});
      end
      @(negedge clk);
      req1_valid = 1'b0;
      n = 0;
      while (rsp1_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (rsp1_data !== (D1 ^ K1)) begin
         errors++;
         $display("FAIL bp_rsp1: got %h expected %h", rsp1_data, D1 ^ K1);
      end
      @(negedge clk);
   endtask

   // With no core answer, 16 WAIT cycles follow ISSUE and the response comes next.
   task automatic test_timeout();
      int n;
      model_en = 1'b0;
      @(negedge clk);
      req0_data = D1; req0_key = K1;
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      n = 0;
      while (rsp0_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== TO + 1) begin
         errors++;
         $display("FAIL timeout_latency: got %0d expected %0d", n, TO + 1);
      end
      checks++;
      if (rsp0_data !== 128'h0 || rsp0_err !== 1'b1 || rsp1_valid !== 1'b0) begin
         errors++;
         $display("FAIL timeout_rsp: got %h err=%b v1=%b expected 0 err=1 v1=0",
                  rsp0_data, rsp0_err, rsp1_valid);
      end
      @(negedge clk);
      core_res_dec   = {4{32'hFFFF_FFFF}};
      core_res_valid = 1'b1;
      @(negedge clk);
      core_res_valid = 1'b0;
      #1;
      checks++;
      if ({busy, rsp0_valid, rsp1_valid, core_data_valid} !== 4'b0000) begin
         errors++;
         $display("FAIL timeout_stray: got %b expected 0000",
                  {busy, rsp0_valid, rsp1_valid, core_data_valid});
      end
      model_en = 1'b1;
   endtask

   // Result lands in WAIT cycle 16 (timer = TIMEOUT-1): the data must win.
   task automatic test_boundary();
      int n;
      model_lat = TO;
      @(negedge clk);
      req0_data = D2; req0_key = K0;
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      n = 0;
      while (rsp0_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== TO + 1) begin
         errors++;
         $display("FAIL boundary_latency: got %0d expected %0d", n, TO + 1);
      end
      checks++;
      if (rsp0_data !== (D2 ^ K0) || rsp0_err !== 1'b0) begin
         errors++;
         $display("FAIL boundary_rsp: got %h err=%b expected %h err=0", rsp0_data, rsp0_err, D2 ^ K0);
      end
      @(negedge clk);
      model_lat = 11;
   endtask

   task automatic test_reset_in_wait();
      int   n;
      logic quiet;
      @(negedge clk);
      req0_data = D0; req0_key = K2;
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, core_data_valid, rsp0_valid, rsp0_err, req0_ready} !== 5'b00000 ||
          (core_data | core_key | rsp0_data) !== 128'h0) begin
         errors++;
         $display("FAIL rst_wait_outputs: got %b %h expected 00000 0",
                  {busy, core_data_valid, rsp0_valid, rsp0_err, req0_ready},
                  core_data | core_key | rsp0_data);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      quiet = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) quiet = 1'b0;
      end
      checks++;
      if (quiet !== 1'b1 || model_cnt !== 0) begin
         errors++;
         $display("FAIL rst_wait_late_result: got quiet=%b cnt=%0d expected 1 0", quiet, model_cnt);
      end
      req0_data = D1; req0_key = K0;
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      n = 0;
      while (rsp0_valid !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n !== 12 || rsp0_data !== (D1 ^ K0) || rsp0_err !== 1'b0) begin
         errors++;
         $display("FAIL rst_wait_next: got n=%0d %h err=%b expected 12 %h 0",
                  n, rsp0_data, rsp0_err, D1 ^ K0);
      end
      @(negedge clk);
   endtask

   initial begin
      reset      = 1'b1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      req0_data  = '0;
      req0_key   = '0;
      req1_data  = '0;
      req1_key   = '0;
      rsp0_ready = 1'b1;
      rsp1_ready = 1'b1;
      test_reset();
      test_tie();
      test_single();
      test_backpressure();
      test_timeout();
      test_boundary();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
